// File: rtl/map_mem_if.sv
// map_mem_if: mapper PRG/CHR strobes and the byte-wide SDRAM controller port seen by map_mem_arbiter
interface map_mem_if #(parameter int ADDR_BITS = 23);
  logic [ADDR_BITS-1:0] prg_addr;
  logic                 prg_oe;
  logic                 prg_we;
  logic                 wram_ce;
  logic [7:0]           cpu_wdata;
  logic [7:0]           prg_rdata;
  logic                 prg_valid;
  logic [ADDR_BITS-1:0] chr_addr;
  logic                 chr_oe;
  logic                 chr_we;
  logic [7:0]           ppu_wdata;
  logic [7:0]           chr_rdata;
  logic                 chr_valid;
  logic                 mem_req;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [7:0]           mem_wdata;
  logic                 mem_ack;
  logic [7:0]           mem_rdata;
  logic                 overrun;
  modport slave (
    input  prg_addr, prg_oe, prg_we, wram_ce, cpu_wdata,
    input  chr_addr, chr_oe, chr_we, ppu_wdata, mem_ack, mem_rdata,
    output prg_rdata, prg_valid, chr_rdata, chr_valid,
    output mem_req, mem_we, mem_addr, mem_wdata, overrun
  );
  modport master (
    output prg_addr, prg_oe, prg_we, wram_ce, cpu_wdata,
    output chr_addr, chr_oe, chr_we, ppu_wdata, mem_ack, mem_rdata,
    input  prg_rdata, prg_valid, chr_rdata, chr_valid,
    input  mem_req, mem_we, mem_addr, mem_wdata, overrun
  );
endinterface

// File: rtl/map_mem_arbiter.sv
// map_mem_arbiter: detects new PRG/CHR accesses and serialises them round-robin onto one SDRAM port
module map_mem_arbiter #(
  parameter int                   ADDR_BITS = 23,
  parameter logic [ADDR_BITS-1:0] PRG_BASE  = ADDR_BITS'('h000000),
  parameter logic [ADDR_BITS-1:0] WRAM_BASE = ADDR_BITS'('h7F0000),
  parameter logic [ADDR_BITS-1:0] CHR_BASE  = ADDR_BITS'('h400000)
) (
  input logic     clk,
  input logic     reset,
  map_mem_if.slave bus
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t               state, state_n;
  logic                 p_prev, c_prev, p_last_we, c_last_we, last_chr;
  logic [ADDR_BITS-1:0] p_last, c_last, p_map, c_map, p_saddr, c_saddr;
  logic                 p_pend, c_pend, p_swe, c_swe;
  logic [7:0]           p_sdata, c_sdata;
  logic                 p_det, c_det, p_drop, c_drop, load, pick_c, take_p, take_c, done;
  assign p_det  = (bus.prg_oe | bus.prg_we) & (~p_prev | (bus.prg_addr != p_last) | (bus.prg_we != p_last_we));
  assign c_det  = (bus.chr_oe | bus.chr_we) & (~c_prev | (bus.chr_addr != c_last) | (bus.chr_we != c_last_we));
  assign p_map  = (bus.wram_ce ? WRAM_BASE : PRG_BASE) + bus.prg_addr;
  assign c_map  = CHR_BASE + bus.chr_addr;
  assign take_p = load & ~pick_c;
  assign take_c = load & pick_c;
  // a slot being granted this cycle is free for the new access
  assign p_drop = p_det & p_pend & p_swe & ~take_p;
  assign c_drop = c_det & c_pend & c_swe & ~take_c;
  assign done   = (state == BUSY) & bus.mem_ack;
  always_comb begin
    pick_c  = c_pend & (~p_pend | ~last_chr);
    load    = (state == IDLE) & (p_pend | c_pend);
    state_n = (state == IDLE) ? (load ? BUSY : IDLE) : (bus.mem_ack ? IDLE : BUSY);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {p_prev, c_prev, p_last_we, c_last_we} <= '0;
      {p_last, c_last, p_saddr, c_saddr} <= '0;
      {p_pend, c_pend, p_swe, c_swe, p_sdata, c_sdata} <= '0;
      bus.overrun <= 1'b0;
    end else begin
      p_prev <= bus.prg_oe | bus.prg_we;
      c_prev <= bus.chr_oe | bus.chr_we;
      if (p_det) {p_last, p_last_we} <= {bus.prg_addr, bus.prg_we};
      if (c_det) {c_last, c_last_we} <= {bus.chr_addr, bus.chr_we};
      if (p_det & ~p_drop) {p_pend, p_swe, p_saddr, p_sdata} <= {1'b1, bus.prg_we, p_map, bus.cpu_wdata};
      else if (take_p) p_pend <= 1'b0;
      if (c_det & ~c_drop) {c_pend, c_swe, c_saddr, c_sdata} <= {1'b1, bus.chr_we, c_map, bus.ppu_wdata};
      else if (take_c) c_pend <= 1'b0;
      bus.overrun <= p_drop | c_drop;
    end
  end
  // last_chr doubles as the channel owning the in-flight transaction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, last_chr} <= '0;
      {bus.prg_rdata, bus.prg_valid, bus.chr_rdata, bus.chr_valid} <= '0;
    end else begin
      bus.prg_valid <= done & ~bus.mem_we & ~last_chr;
      bus.chr_valid <= done & ~bus.mem_we & last_chr;
      if (done & ~bus.mem_we & ~last_chr) bus.prg_rdata <= bus.mem_rdata;
      if (done & ~bus.mem_we & last_chr) bus.chr_rdata <= bus.mem_rdata;
      if (load) begin
        bus.mem_req   <= 1'b1;
        bus.mem_we    <= pick_c ? c_swe : p_swe;
        bus.mem_addr  <= pick_c ? c_saddr : p_saddr;
        bus.mem_wdata <= pick_c ? c_sdata : p_sdata;
        last_chr      <= pick_c;
      end else if (done) bus.mem_req <= 1'b0;
    end
  end
endmodule

// File: tb/tb_map_mem_arbiter.sv
// tb_map_mem_arbiter: randomized scoreboard bench; expected requests/returns queued at issue, checked by monitors
module tb_map_mem_arbiter;
  localparam int AB = 23;
  typedef struct {bit chr; bit we; logic [AB-1:0] addr; logic [7:0] data;} req_t;
  typedef struct {bit chr; logic [7:0] data;} ret_t;
  logic clk = 0, reset = 1;
  always #5 clk = ~clk;
  map_mem_if #(.ADDR_BITS(AB)) bus();
  map_mem_arbiter #(.ADDR_BITS(AB)) dut (.clk(clk), .reset(reset), .bus(bus));
  req_t exp_q[$];
  ret_t ret_q[$];
  int errors = 0, checks = 0, req_cnt = 0, val_cnt = 0, ovr_cnt = 0;
  int fix_delay = -1, fix_rdata = -1;
  bit stall = 0, rr_chr = 0;
  logic [7:0] exp_prd = 0, exp_crd = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [AB-1:0] mapa(bit chr, bit wram, logic [AB-1:0] a);
    logic [AB-1:0] base;
    base = chr ? AB'('h400000) : (wram ? AB'('h7F0000) : AB'(0));
    return base + a;
  endfunction

  // SDRAM responder and request checker
  initial begin : resp
    req_t cur;
    bit in_req;
    int dly;
    in_req = 0; dly = 0; cur = '{0, 0, '0, '0};
    bus.mem_ack = 0; bus.mem_rdata = 0;
    forever begin
      @(negedge clk);
      if (reset) begin in_req = 0; bus.mem_ack = 0; continue; end
      if (bus.mem_ack) begin
        chk("req_gap", 32'(bus.mem_req), 0);
        bus.mem_ack = 0; in_req = 0;
        continue;
      end
      if (!bus.mem_req) begin in_req = 0; continue; end
      if (!in_req) begin
        in_req = 1; req_cnt++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req: addr %0h we %0b, none expected", bus.mem_addr, bus.mem_we);
          cur = '{0, bus.mem_we, bus.mem_addr, bus.mem_wdata};
        end else begin
          cur = exp_q.pop_front();
          chk("req_we", 32'(bus.mem_we), 32'(cur.we));
          chk("req_addr", 32'(bus.mem_addr), 32'(cur.addr));
          if (cur.we) chk("req_wdata", 32'(bus.mem_wdata), 32'(cur.data));
        end
        dly = fix_delay >= 0 ? fix_delay : int'($urandom_range(0, 3));
      end else begin
        chk("hold_we", 32'(bus.mem_we), 32'(cur.we));
        chk("hold_addr", 32'(bus.mem_addr), 32'(cur.addr));
      end
      if (stall) continue;
      if (dly > 0) dly--;
      else begin
        bus.mem_ack = 1;
        bus.mem_rdata = fix_rdata >= 0 ? 8'(fix_rdata) : 8'($urandom);
        if (!cur.we) ret_q.push_back(ret_t'{cur.chr, bus.mem_rdata});
      end
    end
  end

  initial begin : valmon
    ret_t r;
    forever begin
      @(negedge clk);
      if (reset) continue;
      if (bus.prg_valid || bus.chr_valid) begin
        val_cnt++;
        chk("valid_excl", 32'(bus.prg_valid & bus.chr_valid), 0);
        if (ret_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_valid: prg %0b chr %0b, none expected", bus.prg_valid, bus.chr_valid);
        end else begin
          r = ret_q.pop_front();
          chk("valid_chan", 32'(bus.chr_valid), 32'(r.chr));
          if (r.chr) exp_crd = r.data;
          else exp_prd = r.data;
        end
      end
      chk("prg_rdata", 32'(bus.prg_rdata), 32'(exp_prd));
      chk("chr_rdata", 32'(bus.chr_rdata), 32'(exp_crd));
    end
  end

  initial forever begin
    @(negedge clk);
    if (!reset && bus.overrun) ovr_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic idle_inputs();
    {bus.prg_oe, bus.prg_we, bus.wram_ce, bus.chr_oe, bus.chr_we} = '0;
    bus.prg_addr = '0; bus.chr_addr = '0; bus.cpu_wdata = '0; bus.ppu_wdata = '0;
  endtask

  task automatic issue(bit do_p, bit do_c, bit p_we, bit wram, logic [AB-1:0] pa, logic [7:0] pd,
                       bit c_we, logic [AB-1:0] ca, logic [7:0] cd);
    req_t p, c;
    p = '{0, p_we, mapa(0, wram, pa), pd};
    c = '{1, c_we, mapa(1, 0, ca), cd};
    @(posedge clk); #1;
    if (do_p) begin bus.prg_we = p_we; bus.prg_oe = !p_we; bus.wram_ce = wram; bus.prg_addr = pa; bus.cpu_wdata = pd; end
    if (do_c) begin bus.chr_we = c_we; bus.chr_oe = !c_we; bus.chr_addr = ca; bus.ppu_wdata = cd; end
    // round-robin: with both pending the channel not granted last goes first
    if (do_p && do_c) begin
      if (!rr_chr) begin exp_q.push_back(c); exp_q.push_back(p); end
      else begin exp_q.push_back(p); exp_q.push_back(c); end
    end else if (do_p) begin exp_q.push_back(p); rr_chr = 0; end
    else if (do_c) begin exp_q.push_back(c); rr_chr = 1; end
    @(posedge clk); #1;
    {bus.prg_oe, bus.prg_we, bus.chr_oe, bus.chr_we} = '0;
  endtask

  task automatic wait_idle(string name);
    int n = 0;
    while ((exp_q.size() != 0 || ret_q.size() != 0 || bus.mem_req) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL %s timeout: exp_q %0d ret_q %0d req %0b", name, exp_q.size(), ret_q.size(), bus.mem_req);
      exp_q.delete(); ret_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_req(string name);
    int n = 0;
    while (!bus.mem_req && n < 50) begin @(posedge clk); #1; n++; end
    checks++;
    if (n >= 50) begin errors++; $display("FAIL %s: mem_req never rose, expected 1", name); end
  endtask

  initial begin
    int r0, v0, o0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", 32'(bus.mem_req), 0);
    chk("rst_we", 32'(bus.mem_we), 0);
    chk("rst_addr", 32'(bus.mem_addr), 0);
    chk("rst_wdata", 32'(bus.mem_wdata), 0);
    chk("rst_valid", 32'({bus.prg_valid, bus.chr_valid}), 0);
    chk("rst_overrun", 32'(bus.overrun), 0);
    chk("rst_rdata", 32'({bus.prg_rdata, bus.chr_rdata}), 0);
    reset = 0;
    @(posedge clk); #1;
    // single PRG read
    fix_delay = 2; fix_rdata = 'hA5; v0 = val_cnt;
    issue(1, 0, 0, 0, AB'('h01234), 8'h00, 0, '0, 8'h00);
    wait_idle("prg_read");
    chk("prg_read_rdata", 32'(bus.prg_rdata), 32'hA5);
    chk("prg_read_valids", 32'(val_cnt - v0), 1);
    fix_delay = -1; fix_rdata = -1;
    // simultaneous reads: CHR first after a PRG grant
    v0 = val_cnt;
    issue(1, 1, 0, 0, AB'('h00777), 8'h00, 0, AB'('h00042), 8'h00);
    wait_idle("both_read");
    chk("both_read_valids", 32'(val_cnt - v0), 2);
    // WRAM write: no valid
    v0 = val_cnt;
    issue(1, 0, 1, 1, AB'('h0010), 8'h3C, 0, '0, 8'h00);
    wait_idle("wram_write");
    chk("wram_write_no_valid", 32'(val_cnt - v0), 0);
    // steady CHR strobe, address changes while the first is in flight
    r0 = req_cnt; stall = 1;
    @(posedge clk); #1;
    bus.chr_oe = 1; bus.chr_addr = AB'('h0100);
    exp_q.push_back(req_t'{1, 0, mapa(1, 0, AB'('h0100)), 8'h00});
    wait_req("steady_first");
    bus.chr_addr = AB'('h0101);
    exp_q.push_back(req_t'{1, 0, mapa(1, 0, AB'('h0101)), 8'h00});
    repeat (3) @(posedge clk);
    #1; stall = 0;
    wait_idle("steady");
    repeat (5) @(posedge clk);
    #1; bus.chr_oe = 0; rr_chr = 1;
    chk("steady_reqs", 32'(req_cnt - r0), 2);
    // second PRG write dropped behind a stalled CHR read
    o0 = ovr_cnt; stall = 1;
    issue(0, 1, 0, 0, '0, 8'h00, 0, AB'('h0333), 8'h00);
    wait_req("ovr_chr");
    @(posedge clk); #1;
    bus.prg_we = 1; bus.wram_ce = 0; bus.prg_addr = AB'('h0200); bus.cpu_wdata = 8'h11;
    exp_q.push_back(req_t'{0, 1, mapa(0, 0, AB'('h0200)), 8'h11});
    @(posedge clk); #1;
    bus.prg_addr = AB'('h0201); bus.cpu_wdata = 8'h22;
    @(posedge clk); #1;
    bus.prg_we = 0;
    repeat (2) @(posedge clk);
    #1; stall = 0;
    wait_idle("overrun");
    chk("overrun_pulses", 32'(ovr_cnt - o0), 1);
    rr_chr = 0;
    // reset mid-transaction
    stall = 1;
    issue(1, 0, 0, 0, AB'('h0555), 8'h00, 0, '0, 8'h00);
    wait_req("rst_mid_req");
    @(posedge clk); #3;
    reset = 1; #1;
    chk("rst_mid_req_drop", 32'(bus.mem_req), 0);
    exp_q.delete(); ret_q.delete();
    exp_prd = 0; exp_crd = 0; stall = 0; rr_chr = 0;
    @(posedge clk); #1;
    reset = 0; r0 = req_cnt; v0 = val_cnt;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_mid_no_req", 32'(req_cnt - r0), 0);
    chk("rst_mid_no_valid", 32'(val_cnt - v0), 0);
    // random traffic
    for (int i = 0; i < 60; i++) begin
      int mode;
      mode = int'($urandom_range(0, 2));
      issue(mode != 1, mode != 0, 1'($urandom), 1'($urandom), AB'($urandom), 8'($urandom),
            1'($urandom), AB'($urandom), 8'($urandom));
      wait_idle("random");
    end
    chk("final_exp_q", 32'(exp_q.size()), 0);
    chk("final_ret_q", 32'(ret_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
